mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Memory-side stage directly downstream of the address register: consumes the latched address bus (ABUSD) and the data bus, and performs one read or write on the synchronous main-memory RAM per request.
- Inserts a parameterisable number of wait states.
- Returns read data plus a one-cycle done pulse to the control unit.
- Serialises accesses; no queuing.

Parameters:
- ADDR_W, 8, address width; matches the ABUSD width.
- DATA_W, 8, data bus width.
- WAIT_CYC, 2, number of wait-state cycles between ACCESS and DONE; legal range 0..15.

Ports:
- sys_clk  in  1  system clock; all state updates on the rising edge.
- sys_rst  in  1  asynchronous reset, active-high.
- addr_in  in  ADDR_W  address from the address register output (ABUSD).
- wdata_in  in  DATA_W  write data from the data bus.
- rd_req  in  1  read request; sampled only in IDLE.
- wr_req  in  1  write request; sampled only in IDLE.
- busy  out  1  high while a transaction is in flight (state != IDLE).
- done  out  1  one-cycle pulse marking transaction completion.
- rd_data  out  DATA_W  last read result; held until the next read completes.
- req_drop  out  1  one-cycle pulse when a request arrives while busy.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data. The RAM drives it the cycle after an enabled read edge and holds it until its next enabled edge.

Behaviour:
- Reset:
  - Reset is asynchronous and active-high on sys_rst; the clock is sys_clk.
  - While sys_rst is high: state=IDLE, wait counter=0, busy=0, done=0, req_drop=0, rd_data=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - Reset mid-transaction aborts it immediately; no done pulse follows.
  - A write aborted before its ACCESS edge is not performed.
- All outputs are registered; no combinational path from inputs to outputs.
- State machine:
  - IDLE -> ACCESS when rd_req or wr_req is high at a clock edge.
  - ACCESS -> WAIT if WAIT_CYC>0, else -> DONE.
  - WAIT -> DONE after exactly WAIT_CYC cycles in WAIT (counter loads WAIT_CYC-1 on entry and decrements to 0).
  - DONE -> IDLE unconditionally.
- Acceptance, on the edge entering ACCESS:
  - addr_in is latched into ram_addr; wdata_in is latched into ram_wdata (writes only).
  - The operation type is latched.
  - Inputs may change freely after acceptance.
- Simultaneous rd_req and wr_req in IDLE: write wins; the read is discarded with no req_drop.
- ACCESS (exactly 1 cycle): ram_en=1; ram_we=1 only for writes.
- WAIT and DONE: ram_en=0, ram_we=0; ram_addr and ram_wdata are held.
- Edge leaving DONE:
  - done=1 for that one cycle.
  - For reads, rd_data is loaded from ram_rdata.
  - For writes, rd_data is unchanged.
- Latency: done is high in cycle WAIT_CYC+3 counting the request-sampling edge as 0. This gives 5 cycles at the default and 3 cycles at WAIT_CYC=0.
- busy is high for the ACCESS, WAIT and DONE cycles, and low in the cycle done is high.
- Back-to-back: a request present in the cycle done is high is accepted (the state is IDLE).
- Any rd_req or wr_req while busy=1 is ignored and produces req_drop=1 on the next cycle. The in-flight transaction is unaffected.
- Address wrap-around has no special meaning; ram_addr is passed through unmodified across the full 0..2^ADDR_W-1 range.

Decomposition:
- Shared package cpu_pkg holds:
  - the state encoding localparams (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3);
  - the bus width constants ADDR_W=8 and DATA_W=8;
  - the op-type constants OP_RD and OP_WR.
- No sub-module is required. The 4-bit wait-state down-counter is inline logic.
- The testbench provides a behavioural synchronous RAM model (sync_ram_model) that follows the ram_rdata hold rule.

Test Plan:
- Write then read at default WAIT_CYC=2:
  - Write 0xA5 to 0x3C -> ram_we high for exactly 1 cycle with ram_addr=0x3C; done in cycle 5.
  - Read 0x3C -> rd_data=0xA5 when done; busy high for exactly 4 cycles per transaction.
- WAIT_CYC=0: read of 0xFF (preloaded 0x5A) -> done in cycle 3, rd_data=0x5A; then read 0x00 -> rd_data=the preloaded value at 0x00 (address range edges).
- Simultaneous rd_req=wr_req=1 with addr 0x10 and wdata 0x77 -> only a write occurs (RAM[0x10]=0x77), no req_drop; rd_data is unchanged from its prior value.
- Request during busy: rd_req pulsed in the WAIT cycle -> req_drop=1 one cycle later, no extra RAM enable, first done still in cycle 5. Then a request held high in the done cycle -> accepted back-to-back, with the second done 5 cycles later.
- Address change after acceptance: addr_in is switched from 0x20 to 0x21 the cycle after the request -> ram_addr stays 0x20 until DONE.
- Reset asserted asynchronously mid-WAIT (between clock edges) -> all outputs drop to 0 immediately, no done pulse. After release, a new read completes normally in 5 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, state encoding and op codes for the memory access stage
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request/response bus between the control unit and the memory stage
interface mem_access_ctrl_if #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DATA_W = cpu_pkg::DATA_W
);

    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic              rd_req;
    logic              wr_req;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rd_data;
    logic              req_drop;

    modport master (
        output addr_in, wdata_in, rd_req, wr_req,
        input  busy, done, rd_data, req_drop
    );

    modport slave (
        input  addr_in, wdata_in, rd_req, wr_req,
        output busy, done, rd_data, req_drop
    );

endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - serialised single-access controller for the synchronous main-memory RAM
module mem_access_ctrl #(
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int WAIT_CYC = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    mem_access_ctrl_if.slave  bus,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    import cpu_pkg::*;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    op_t               op_q;
    logic              busy_q, done_q, drop_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              any_req, accept;

    assign any_req = bus.rd_req | bus.wr_req;
    assign accept  = (state_q == IDLE) && any_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS: begin
                if (WAIT_CYC > 0) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end else begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            op_q      <= OP_RD;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
            rd_data_q <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_q == DONE);
            drop_q  <= (state_q != IDLE) && any_req;
            ram_en  <= accept;
            ram_we  <= accept && bus.wr_req;
            if (accept) begin
                op_q     <= bus.wr_req ? OP_WR : OP_RD;
                ram_addr <= bus.addr_in;
                if (bus.wr_req) ram_wdata <= bus.wdata_in;
            end
            if (state_q == DONE && op_q == OP_RD) rd_data_q <= ram_rdata;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.req_drop = drop_q;
    assign bus.rd_data  = rd_data_q;

endmodule
